// File: rtl/aes_spi_slave_frontend.sv
// aes_spi_slave_frontend: bit-serial SPI front end that loads msg/key into an AES core and streams its result back.
module aes_spi_slave_frontend #(
  parameter int NB = 4,
  parameter int NK = 4,
  localparam int DW = 32*NB,
  localparam int KW = 32*NK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          Mosi,
  output logic          Miso,
  output logic [DW-1:0] core_msg,
  output logic [KW-1:0] core_key,
  output logic          core_start,
  input  logic          core_done,
  input  logic [DW-1:0] core_result,
  output logic          out_valid
);
  localparam int FW = DW + KW;
  localparam logic [2:0] IDLE = 3'd0, RX = 3'd1, START = 3'd2, WAIT = 3'd3, TX = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [8:0]    rx_cnt_q, rx_cnt_d;
  logic [6:0]    tx_cnt_q, tx_cnt_d;
  logic [FW-1:0] shift_q, shift_d;
  logic [DW-1:0] tx_q, tx_d, msg_q, msg_d;
  logic [KW-1:0] key_q, key_d;
  assign core_msg   = msg_q;
  assign core_key   = key_q;
  assign core_start = state_q == START;
  assign out_valid  = state_q == TX;
  assign Miso       = state_q == TX ? tx_q[DW-1] : 1'b0;
  always_comb begin
    state_d  = state_q;
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    msg_d    = msg_q;
    key_d    = key_q;
    case (state_q)
      IDLE: if (cs) begin
        shift_d  = {shift_q[FW-2:0], Mosi};
        rx_cnt_d = 9'd1;
        state_d  = RX;
      end
      RX: if (!cs) begin
        rx_cnt_d = 9'd0;
        state_d  = IDLE;
      end else begin
        shift_d  = {shift_q[FW-2:0], Mosi};
        rx_cnt_d = rx_cnt_q + 9'd1;
        // the final bit is included in the latched block via shift_d
        if (rx_cnt_q == 9'(FW-1)) begin
          {msg_d, key_d} = shift_d;
          rx_cnt_d       = 9'd0;
          state_d        = START;
        end
      end
      START: state_d = WAIT;
      WAIT: if (core_done) begin
        tx_d     = core_result;
        tx_cnt_d = 7'd0;
        state_d  = TX;
      end
      TX: if (cs) begin
        tx_d     = {tx_q[DW-2:0], 1'b0};
        tx_cnt_d = tx_cnt_q + 7'd1;
        state_d  = tx_cnt_q == 7'(DW-1) ? IDLE : TX;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      msg_q    <= '0;
      key_q    <= '0;
    end else begin
      state_q  <= state_d;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      msg_q    <= msg_d;
      key_q    <= key_d;
    end
  end
endmodule

// File: tb/tb_aes_spi_slave_frontend.sv
// tb_aes_spi_slave_frontend: directed bench with a Miso bit scoreboard filled when the model core answers.
module tb_aes_spi_slave_frontend;
  logic         clk = 0, rst = 1, cs = 0, Mosi = 0, core_done = 0;
  logic [127:0] core_result = '0, core_msg, core_key;
  logic         Miso, core_start, out_valid;
  int           checks = 0, errors = 0;
  logic         exp_q[$];
  localparam logic [255:0] F1 = {128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [255:0] F2 = {128'hdeadbeef0123456789abcdef55aa33cc, 128'hffeeddccbbaa99887766554433221100};
  localparam logic [255:0] F3 = {128'h1234567890abcdef1122334455667788, 128'h0f0e0d0c0b0a09080706050403020100};
  localparam logic [127:0] R1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R2 = 128'h8000000000000001a5a5a5a55a5a5a5a;

  aes_spi_slave_frontend #(.NB(4), .NK(4)) dut (
    .clk(clk), .rst(rst), .cs(cs), .Mosi(Mosi), .Miso(Miso),
    .core_msg(core_msg), .core_key(core_key), .core_start(core_start),
    .core_done(core_done), .core_result(core_result), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [255:0] f, input int n, input int done_at);
    int starts = 0;
    for (int i = 0; i < n; i++) begin
      cs = 1;
      Mosi = f[255-i];
      core_done = (i == done_at);
      core_result = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
      tick();
      if (core_start && i != 255) starts++;
    end
    core_done = 0;
    chk("no_early_start", 256'(starts), 256'd0);
  endtask

  task automatic full_frame(input logic [255:0] f, input int done_at);
    send_frame(f, 256, done_at);
    chk("start_high", 256'(core_start), 256'd1);
    chk("core_msg", 256'(core_msg), 256'(f[255:128]));
    chk("core_key", 256'(core_key), 256'(f[127:0]));
    cs = 0;
    Mosi = 0;
    tick();
    chk("start_one_cycle", 256'(core_start), 256'd0);
  endtask

  task automatic core_answer(input logic [127:0] r);
    repeat (9) begin
      cs = 1;
      Mosi = ~Mosi;
      tick();
    end
    chk("wait_no_valid", 256'(out_valid), 256'd0);
    chk("wait_miso_zero", 256'(Miso), 256'd0);
    cs = 0;
    core_done = 1;
    core_result = r;
    for (int k = 0; k < 128; k++) exp_q.push_back(r[127-k]);
    tick();
    core_done = 0;
    core_result = '0;
    chk("valid_rise", 256'(out_valid), 256'd1);
    chk("miso_first", 256'(Miso), 256'(r[127]));
  endtask

  task automatic shift_out(input logic [127:0] r, input int pause_at, input logic [127:0] msg);
    logic [127:0] got = '0;
    logic e;
    for (int k = 0; k < 128; k++) begin
      if (k == pause_at) begin
        cs = 0;
        repeat (5) begin
          Mosi = 1'($urandom);
          tick();
          chk("pause_hold", 256'(Miso), 256'(exp_q[0]));
          chk("pause_valid", 256'(out_valid), 256'd1);
        end
      end
      e = exp_q.pop_front();
      chk("miso_bit", 256'(Miso), 256'(e));
      got = {got[126:0], Miso};
      cs = 1;
      Mosi = 1'($urandom);
      tick();
    end
    cs = 0;
    chk("valid_fall", 256'(out_valid), 256'd0);
    chk("miso_idle", 256'(Miso), 256'd0);
    chk("result_word", 256'(got), 256'(r));
    chk("msg_kept_tx", 256'(core_msg), 256'(msg));
  endtask

  initial begin
    rst = 1;
    tick();
    chk("rst_miso", 256'(Miso), 256'd0);
    chk("rst_start", 256'(core_start), 256'd0);
    chk("rst_valid", 256'(out_valid), 256'd0);
    chk("rst_msg", 256'(core_msg), 256'd0);
    chk("rst_key", 256'(core_key), 256'd0);
    rst = 0;
    tick();
    // FIPS-197 frame with a stray core_done during receive
    full_frame(F1, 50);
    core_answer(R1);
    shift_out(R1, -1, F1[255:128]);
    // aborted partial frame leaves the latched block untouched
    send_frame(F2, 100, -1);
    cs = 0;
    tick();
    tick();
    chk("abort_no_start", 256'(core_start), 256'd0);
    chk("abort_msg", 256'(core_msg), 256'(F1[255:128]));
    chk("abort_key", 256'(core_key), 256'(F1[127:0]));
    full_frame(F2, -1);
    core_answer(R2);
    shift_out(R2, 40, F2[255:128]);
    // reset while waiting on the core
    full_frame(F3, -1);
    tick();
    tick();
    rst = 1;
    #1;
    chk("arst_miso", 256'(Miso), 256'd0);
    chk("arst_start", 256'(core_start), 256'd0);
    chk("arst_valid", 256'(out_valid), 256'd0);
    chk("arst_msg", 256'(core_msg), 256'd0);
    chk("arst_key", 256'(core_key), 256'd0);
    tick();
    rst = 0;
    tick();
    core_done = 1;
    core_result = R1;
    tick();
    core_done = 0;
    chk("late_done_ignored", 256'(out_valid), 256'd0);
    chk("late_done_miso", 256'(Miso), 256'd0);
    tick();
    chk("still_idle", 256'(out_valid), 256'd0);
    chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
